spi_sensor_reader: RTL



---
 rtl/spi_sensor_reader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_sensor_reader.sv
// SPI master that reads fixed-length frames from a read-only sensor and
// hands an extracted bit field to a valid/ready consumer, flagging overruns.
`timescale 1ns/1ps
module spi_sensor_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_MSB   = 11,
  parameter int DATA_LSB   = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int GAP        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cont,
  output logic                         busy,
  output logic                         ss,
  output logic                         sclk,
  input  logic                         miso,
  output logic [FRAME_BITS-1:0]        frame_raw,
  output logic [DATA_MSB-DATA_LSB:0]   data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic                         overrun
);

  localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2      = (CS_HOLD > GAP) ? CS_HOLD : GAP;
  localparam int CYC_MAX = (M1 > M2) ? M1 : M2;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(CS_SETUP - 1);
  localparam logic [CYC_W-1:0] DIV_LAST   = CYC_W'(CLK_DIV - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(CS_HOLD - 1);
  localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                       state_r;
  logic [CYC_W-1:0]             cyc_r;
  logic [BIT_W-1:0]             bit_r;
  logic [FRAME_BITS-1:0]        sr_r;
  logic                         ss_r;
  logic                         sclk_r;
  logic                         busy_r;
  logic [FRAME_BITS-1:0]        frame_raw_r;
  logic [DATA_MSB-DATA_LSB:0]   data_out_r;
  logic                         data_valid_r;
  logic                         overrun_r;
  logic                         load_s;

  // The result is captured on the last HOLD cycle, the same edge that raises ss.
  assign load_s = (state_r == ST_HOLD) && (cyc_r == HOLD_LAST);

  // Frame sequencer: drives ss, sclk, busy and shifts miso in on each sclk rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cyc_r   <= '0;
      bit_r   <= '0;
      sr_r    <= '0;
      ss_r    <= 1'b1;
      sclk_r  <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start || cont) begin
            state_r <= ST_SETUP;
            ss_r    <= 1'b0;
            busy_r  <= 1'b1;
            cyc_r   <= '0;
          end
        end
        ST_SETUP: begin
          if (cyc_r == SETUP_LAST) begin
            state_r <= ST_SHIFT;
            sclk_r  <= 1'b0;
            cyc_r   <= '0;
            bit_r   <= '0;
          end else begin
            cyc_r <= cyc_r + CYC_W'(1);
          end
        end
        ST_SHIFT: begin
          if (cyc_r != DIV_LAST) begin
            cyc_r <= cyc_r + CYC_W'(1);
          end else begin
            cyc_r <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
              sr_r   <= {sr_r[FRAME_BITS-2:0], miso};
            end else if (bit_r == BIT_LAST) begin
              state_r <= ST_HOLD;
            end else begin
              sclk_r <= 1'b0;
              bit_r  <= bit_r + BIT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (load_s) begin
            ss_r  <= 1'b1;
            cyc_r <= '0;
            if (cont) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cyc_r <= cyc_r + CYC_W'(1);
          end
        end
        ST_GAP: begin
          if (cyc_r == GAP_LAST) begin
            cyc_r <= '0;
            if (cont) begin
              state_r <= ST_SETUP;
              ss_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cyc_r <= cyc_r + CYC_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cyc_r   <= '0;
          ss_r    <= 1'b1;
          sclk_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Result register and handshake; a load wins over an accept on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_raw_r  <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (load_s) begin
      frame_raw_r  <= sr_r;
      data_out_r   <= sr_r[DATA_MSB:DATA_LSB];
      data_valid_r <= 1'b1;
      if (data_valid_r && !data_ready) begin
        overrun_r <= 1'b1;
      end
    end else if (data_valid_r && data_ready) begin
      data_valid_r <= 1'b0;
    end
  end

  assign busy       = busy_r;
  assign ss         = ss_r;
  assign sclk       = sclk_r;
  assign frame_raw  = frame_raw_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign overrun    = overrun_r;

endmodule
